// File: rtl/vram_write_arbiter_if.sv
// Bundle of the CPU write path, GPU read path and shared VRAM port signals.
// The arbiter uses the slave modport; the surrounding system drives the master side.
interface vram_write_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  logic                     cpu_write_valid;
  logic [ADDR_W-1:0]        cpu_write_address;
  logic [7:0]               cpu_write_data;
  logic                     cpu_write_ready;
  logic                     in_vblank;
  logic                     gpu_read_request;
  logic [ADDR_W-1:0]        gpu_read_address;
  logic                     gpu_read_grant;
  logic [ADDR_W-1:0]        vram_address;
  logic [7:0]               vram_data;
  logic                     vram_write_enable;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic                     clear_overflow;

  modport master (
    output cpu_write_valid, cpu_write_address, cpu_write_data, in_vblank,
           gpu_read_request, gpu_read_address, clear_overflow,
    input  cpu_write_ready, gpu_read_grant, vram_address, vram_data,
           vram_write_enable, fifo_count, overflow
  );

  modport slave (
    input  cpu_write_valid, cpu_write_address, cpu_write_data, in_vblank,
           gpu_read_request, gpu_read_address, clear_overflow,
    output cpu_write_ready, gpu_read_grant, vram_address, vram_data,
           vram_write_enable, fifo_count, overflow
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Shares the single VRAM port between buffered CPU writes and GPU reads.
// GPU reads win unless in vblank, the GPU is idle, or a queued write has starved too long.
module vram_write_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 32
) (
  input logic                 clk,
  input logic                 rst,
  vram_write_arbiter_if.slave bus
);
  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [7:0]        LIMIT      = 8'(STARVE_LIMIT);

  logic [ADDR_W-1:0] address_mem [DEPTH];
  logic [7:0]        data_mem    [DEPTH];
  logic [PTR_W-1:0]  read_ptr;
  logic [PTR_W-1:0]  write_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        wait_count;
  logic              overflow_flag;

  logic empty;
  logic full;
  logic force_write;
  logic drain;
  logic push;
  logic drop;

  // Fullness uses the pre-edge count, so a push at DEPTH is dropped even if a pop coincides.
  assign empty       = (count == '0);
  assign full        = (count == FULL_COUNT);
  assign force_write = (STARVE_LIMIT != 0) && (wait_count == LIMIT);
  assign drain       = !empty && (bus.in_vblank || !bus.gpu_read_request || force_write);
  assign push        = bus.cpu_write_valid && !full;
  assign drop        = bus.cpu_write_valid && full;

  always_ff @(posedge clk) begin
    if (push) begin
      address_mem[write_ptr] <= bus.cpu_write_address;
      data_mem[write_ptr]    <= bus.cpu_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_ptr      <= '0;
      write_ptr     <= '0;
      count         <= '0;
      wait_count    <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (push) write_ptr <= write_ptr + 1'b1;
      if (drain) read_ptr <= read_ptr + 1'b1;

      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Saturates at the limit; a limit of zero leaves it parked at zero.
      if (empty || drain) wait_count <= '0;
      else if (wait_count != LIMIT) wait_count <= wait_count + 1'b1;

      if (drop) overflow_flag <= 1'b1;
      else if (bus.clear_overflow) overflow_flag <= 1'b0;
    end
  end

  assign bus.cpu_write_ready   = !full;
  assign bus.vram_write_enable = drain;
  assign bus.vram_address      = drain ? address_mem[read_ptr] : bus.gpu_read_address;
  assign bus.vram_data         = data_mem[read_ptr];
  assign bus.gpu_read_grant    = bus.gpu_read_request && !drain;
  assign bus.fifo_count        = count;
  assign bus.overflow          = overflow_flag;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed and randomized checks of vram_write_arbiter against a queue-based reference model.
module tb_vram_write_arbiter;
  localparam int ADDR_W       = 12;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  logic clk = 1'b0;
  logic rst;

  vram_write_arbiter_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  vram_write_arbiter #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  entry_t model_q[$];
  int     model_wait = 0;
  logic   model_ovf  = 1'b0;
  int     checks_total  = 0;
  int     checks_passed = 0;

  task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h required %0h at %0t", name, observed, expected, $time);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, then advance the model.
  task automatic apply_stimulus(
    input logic              valid,
    input logic [ADDR_W-1:0] waddr,
    input logic [7:0]        wdata,
    input logic              vblank,
    input logic              req,
    input logic [ADDR_W-1:0] raddr,
    input logic              clr,
    input logic              reset_in
  );
    logic              exp_drain;
    logic [ADDR_W-1:0] exp_addr;
    int                pre;
    logic              dropped;
    @(negedge clk);
    rst                   = reset_in;
    bus.cpu_write_valid   = valid;
    bus.cpu_write_address = waddr;
    bus.cpu_write_data    = wdata;
    bus.in_vblank         = vblank;
    bus.gpu_read_request  = req;
    bus.gpu_read_address  = raddr;
    bus.clear_overflow    = clr;
    #1;
    pre       = model_q.size();
    exp_drain = (pre > 0) &&
                (vblank || !req || (STARVE_LIMIT != 0 && model_wait == STARVE_LIMIT));
    exp_addr  = exp_drain ? model_q[0].addr : raddr;
    check_output("fifo_count", 32'(bus.fifo_count), 32'(pre));
    check_output("cpu_write_ready", 32'(bus.cpu_write_ready), 32'(pre != DEPTH));
    check_output("vram_write_enable", 32'(bus.vram_write_enable), 32'(exp_drain));
    check_output("gpu_read_grant", 32'(bus.gpu_read_grant), 32'(req && !exp_drain));
    check_output("vram_address", 32'(bus.vram_address), 32'(exp_addr));
    check_output("overflow", 32'(bus.overflow), 32'(model_ovf));
    if (exp_drain) check_output("vram_data", 32'(bus.vram_data), 32'(model_q[0].data));

    if (reset_in) begin
      model_q.delete();
      model_wait = 0;
      model_ovf  = 1'b0;
    end else begin
      dropped = 1'b0;
      if (pre == 0 || exp_drain) model_wait = 0;
      else if (model_wait < STARVE_LIMIT) model_wait++;
      if (exp_drain) void'(model_q.pop_front());
      if (valid) begin
        if (pre < DEPTH) model_q.push_back('{addr: waddr, data: wdata});
        else dropped = 1'b1;
      end
      if (dropped) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
    end
  endtask

  task automatic write_cycle(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic req, input logic vblank, input logic clr);
    apply_stimulus(1'b1, a, d, vblank, req, ADDR_W'($urandom), clr, 1'b0);
  endtask

  task automatic idle_cycles(input int n, input logic req, input logic vblank);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, '0, '0, vblank, req, ADDR_W'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    rst                   = 1'b1;
    bus.cpu_write_valid   = 1'b0;
    bus.cpu_write_address = '0;
    bus.cpu_write_data    = '0;
    bus.in_vblank         = 1'b0;
    bus.gpu_read_request  = 1'b0;
    bus.gpu_read_address  = '0;
    bus.clear_overflow    = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] reset then idle");
    idle_cycles(2, 1'b0, 1'b0);
    idle_cycles(2, 1'b1, 1'b0);

    $display("[TB] single write with GPU idle");
    write_cycle(12'h123, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b0, 1'b0);

    $display("[TB] starvation forcing with GPU busy");
    write_cycle(12'h010, 8'h11, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h020, 8'h22, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h030, 8'h33, 1'b1, 1'b0, 1'b0);
    idle_cycles(3 * (STARVE_LIMIT + 1) + 4, 1'b1, 1'b0);

    $display("[TB] overflow and vblank drain");
    for (int i = 0; i < 5; i++) write_cycle(ADDR_W'(12'h200 + i), 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    idle_cycles(4, 1'b1, 1'b1);
    idle_cycles(1, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) write_cycle(ADDR_W'(12'h300 + i), 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
    write_cycle(12'h3FF, 8'hEE, 1'b1, 1'b0, 1'b1);
    idle_cycles(1, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, '0, 1'b1, 1'b0);
    idle_cycles(5, 1'b0, 1'b0);

    $display("[TB] simultaneous push and pop");
    write_cycle(12'h401, 8'h81, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h402, 8'h82, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h403, 8'h83, 1'b0, 1'b0, 1'b0);
    idle_cycles(1, 1'b1, 1'b0);
    write_cycle(12'h404, 8'h84, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h405, 8'h85, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h406, 8'h86, 1'b0, 1'b0, 1'b0);
    idle_cycles(6, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-drain");
    write_cycle(12'h501, 8'h91, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h502, 8'h92, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h503, 8'h93, 1'b1, 1'b0, 1'b0);
    write_cycle(12'h504, 8'h94, 1'b1, 1'b0, 1'b0);
    idle_cycles(1, 1'b1, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
    idle_cycles(3, 1'b0, 1'b1);
    idle_cycles(STARVE_LIMIT + 3, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 2) == 0, ADDR_W'($urandom), 8'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 8,
                     ADDR_W'($urandom), $urandom_range(0, 19) == 0,
                     $urandom_range(0, 199) == 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
